// File: rtl/date_counter.sv
// date_counter: BCD month/day calendar stage with leap-year handling, day advance and validated direct load
module date_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       increase,
  input  logic       leap,
  input  logic       load,
  input  logic [3:0] load_m1,
  input  logic [3:0] load_m0,
  input  logic [3:0] load_d1,
  input  logic [3:0] load_d0,
  output logic [3:0] val0,
  output logic [3:0] val1,
  output logic [3:0] val2,
  output logic [3:0] val3,
  output logic       year_carry,
  output logic       load_err
);
  function automatic logic [6:0] bin(input logic [3:0] t, input logic [3:0] u);
    return {3'b0, t} * 7'd10 + {3'b0, u};
  endfunction
  function automatic logic [6:0] last_of(input logic [6:0] m, input logic lp);
    return (m == 7'd2) ? (lp ? 7'd29 : 7'd28) :
           (m == 7'd4 || m == 7'd6 || m == 7'd9 || m == 7'd11) ? 7'd30 : 7'd31;
  endfunction
  logic [6:0] cur_m, cur_d, ld_m, ld_d;
  logic       at_last, wrap_m, digits_ok, load_ok;
  logic [3:0] n0, n1, n2, n3;
  always_comb begin
    cur_m = bin(val3, val2);
    cur_d = bin(val1, val0);
    ld_m = bin(load_m1, load_m0);
    ld_d = bin(load_d1, load_d0);
    // >= so an illegal held Feb 29 in a non-leap year still rolls over to 03/01
    at_last = cur_d >= last_of(cur_m, leap);
    wrap_m = cur_m >= 7'd12;
    n0 = at_last ? 4'd1 : (val0 == 4'd9) ? 4'd0 : val0 + 4'd1;
    n1 = at_last ? 4'd0 : (val0 == 4'd9) ? val1 + 4'd1 : val1;
    n2 = !at_last ? val2 : wrap_m ? 4'd1 : (val2 == 4'd9) ? 4'd0 : val2 + 4'd1;
    n3 = !at_last ? val3 : wrap_m ? 4'd0 : (val2 == 4'd9) ? val3 + 4'd1 : val3;
    digits_ok = load_m1 <= 4'd9 && load_m0 <= 4'd9 && load_d1 <= 4'd9 && load_d0 <= 4'd9;
    load_ok = digits_ok && ld_m >= 7'd1 && ld_m <= 7'd12 && ld_d >= 7'd1 &&
              ld_d <= last_of(ld_m, leap);
    year_carry = increase & ~load & (cur_m == 7'd12) & (cur_d == 7'd31);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {val3, val2, val1, val0} <= 16'h0101;
      load_err <= 1'b0;
    end else begin
      load_err <= load & ~load_ok;
      if (load) begin
        if (load_ok) {val3, val2, val1, val0} <= {load_m1, load_m0, load_d1, load_d0};
      end else if (increase) begin
        {val3, val2, val1, val0} <= {n3, n2, n1, n0};
      end
    end
  end
endmodule
